// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: MSB-first deframer feeding a 2-entry output FIFO
// with sticky overrun reporting when a completed word finds the buffer full.
module sipo_rx #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             bit_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam int CW    = $clog2(WIDTH);
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word;
    logic             word_done;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overrun_q, overrun_d;
    logic             full, pop, push, drop;

    assign word = {shreg_q[WIDTH-2:0], data_in};

    // Deframer: the bit count alone encodes IDLE (0) versus SHIFT (non-zero).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (frame_start) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (bit_en) begin
                shreg_d = {{(WIDTH-1){1'b0}}, data_in};
                cnt_d   = CW'(1);
            end
        end else if (bit_en) begin
            shreg_d = word;
            if (cnt_q == LAST_BIT) begin
                word_done = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign full = (level_q == FULL_LVL);
    assign pop  = (level_q != '0) && dout_ready;
    // A pop on the same edge frees the slot the new word lands in, so it is never dropped.
    assign push = word_done && (!full || pop);
    assign drop = word_done && full && !pop;

    always_comb begin
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        overrun_d = drop | (overrun_q & ~clr_ovr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            shreg_q   <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the storage array is not reset; an empty buffer is defined by level_q and dout is masked.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign dout_valid = (level_q != '0);
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
    assign overrun    = overrun_q;
    assign busy       = (cnt_q != '0);

endmodule
